// File: rtl/gsm_cmd_sequencer.sv
// Initiator for the game-state-manager command handshake: captures game events, picks the
// command that is due and drives it over flag/trig/done with a timeout.
module gsm_cmd_sequencer #(
    parameter int unsigned MAX_STAGE = 3,
    parameter int unsigned PEND_W    = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned GAP       = 2
) (
    input  logic              clk_1mhz,
    input  logic              rst_n,
    input  logic              hit_pulse,
    input  logic              miss_pulse,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic [2:0]        gsm_state,
    input  logic [1:0]        gsm_stage,
    input  logic [1:0]        gsm_lives,
    input  logic [6:0]        gsm_timer,
    input  logic              gsm_timer_running,
    input  logic              done,
    output logic [3:0]        flag,
    output logic              trig,
    output logic              busy,
    output logic              err,
    output logic [PEND_W-1:0] hit_pend,
    output logic [PEND_W-1:0] miss_pend
);

    localparam int unsigned CntMax = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] GapLast = CntW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PEND_W-1:0] PendMax = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [3:0]         flag_q, flag_d;
    logic               trig_q, trig_d;
    logic               err_q, err_d;
    logic [PEND_W-1:0]  hit_q, hit_d, miss_q, miss_d;
    logic               start_q, start_d, pause_q, pause_d;

    logic               playing, start_legal;
    logic               sel_valid;
    logic [3:0]         sel_flag;
    logic               hit_dec, miss_dec, clr_pend, clr_pause, clr_start;

    assign playing     = (gsm_state == 3'd1);
    assign start_legal = (gsm_state == 3'd0) || (gsm_state == 3'd3) ||
                         (gsm_state == 3'd4) || (gsm_state == 3'd5);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        trig_d    = 1'b0;
        err_d     = err_q;
        sel_valid = 1'b0;
        sel_flag  = 4'b0000;
        hit_dec   = 1'b0;
        miss_dec  = 1'b0;
        clr_pend  = 1'b0;
        clr_pause = 1'b0;
        clr_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (playing && gsm_lives == 2'd0) begin
                    sel_valid = 1'b1;
                    sel_flag  = 4'b1101;
                end else if (playing && gsm_timer == 7'd0 && !gsm_timer_running) begin
                    sel_valid = 1'b1;
                    sel_flag  = (gsm_stage == 2'(MAX_STAGE)) ? 4'b1110 : 4'b1100;
                end else if (playing && miss_q != '0) begin
                    sel_valid = 1'b1;
                    sel_flag  = 4'b0010;
                    miss_dec  = 1'b1;
                end else if (playing && hit_q != '0) begin
                    sel_valid = 1'b1;
                    sel_flag  = 4'b0001;
                    hit_dec   = 1'b1;
                end else if (playing && pause_q) begin
                    sel_valid = 1'b1;
                    sel_flag  = gsm_timer_running ? 4'b0100 : 4'b0101;
                    clr_pause = 1'b1;
                end else if (start_q && start_legal) begin
                    sel_valid = 1'b1;
                    clr_start = 1'b1;
                    case (gsm_state)
                        3'd0:       sel_flag = 4'b1010;
                        3'd4:       sel_flag = 4'b1000;
                        default:    sel_flag = 4'b1111;
                    endcase
                end
                // Events with no legal command in this state are dropped
                if (!start_legal) clr_start = 1'b1;
                if (!playing) clr_pend = 1'b1;
                if (sel_valid) begin
                    flag_d  = sel_flag;
                    state_d = StIssue;
                    cnt_d   = '0;
                    if (sel_flag[3]) clr_pend = 1'b1;
                end
            end
            StIssue: begin
                trig_d = 1'b1;
                if (trig_q && done) begin
                    trig_d  = 1'b0;
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if (trig_q) begin
                    if (cnt_q == ToLast) begin
                        trig_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = StRelease;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRelease: begin
                if (done) begin
                    cnt_d = '0;
                end else if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating event counters; a simultaneous increment and dequeue cancel out
    always_comb begin
        hit_d   = hit_q;
        miss_d  = miss_q;
        start_d = btn_start ? 1'b1 : (clr_start ? 1'b0 : start_q);
        pause_d = btn_pause ? 1'b1 : ((clr_pend || clr_pause) ? 1'b0 : pause_q);
        if (clr_pend) begin
            hit_d = '0;
        end else if (hit_pulse && playing && !hit_dec) begin
            if (hit_q != PendMax) hit_d = hit_q + 1'b1;
        end else if (hit_dec && !(hit_pulse && playing)) begin
            hit_d = hit_q - 1'b1;
        end
        if (clr_pend) begin
            miss_d = '0;
        end else if (miss_pulse && playing && !miss_dec) begin
            if (miss_q != PendMax) miss_d = miss_q + 1'b1;
        end else if (miss_dec && !(miss_pulse && playing)) begin
            miss_d = miss_q - 1'b1;
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flag_q  <= 4'b0000;
            trig_q  <= 1'b0;
            err_q   <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            trig_q  <= trig_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            start_q <= start_d;
            pause_q <= pause_d;
        end
    end

    assign flag      = flag_q;
    assign trig      = trig_q;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign hit_pend  = hit_q;
    assign miss_pend = miss_q;

endmodule

// File: tb/tb_gsm_cmd_sequencer.sv
// Bench for gsm_cmd_sequencer: vector table plus hand sequences, commands checked by a
// scoreboard queue popped on every trig rising edge.
`timescale 1ns/1ps
module tb_gsm_cmd_sequencer;

    logic       clk_1mhz;
    logic       rst_n;
    logic       hit_pulse, miss_pulse, btn_start, btn_pause;
    logic [2:0] gsm_state;
    logic [1:0] gsm_stage, gsm_lives;
    logic [6:0] gsm_timer;
    logic       gsm_timer_running;
    logic       done;
    logic [3:0] flag;
    logic       trig, busy, err;
    logic [3:0] hit_pend, miss_pend;

    logic manual, man_done, auto_en, auto_val;
    assign done = manual ? man_done : auto_val;

    int n_vec  = 0;
    int n_fail = 0;
    logic [3:0] exp_q [$];

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] stage;
        logic [1:0] lives;
        logic [6:0] timer;
        logic       run;
        logic [2:0] ev;     // 0 none, 1 hit, 2 miss, 3 start, 4 pause
        logic [3:0] want;
        logic       issue;
    } vec_t;
    vec_t vec [14];

    gsm_cmd_sequencer dut (
        .clk_1mhz         (clk_1mhz),
        .rst_n            (rst_n),
        .hit_pulse        (hit_pulse),
        .miss_pulse       (miss_pulse),
        .btn_start        (btn_start),
        .btn_pause        (btn_pause),
        .gsm_state        (gsm_state),
        .gsm_stage        (gsm_stage),
        .gsm_lives        (gsm_lives),
        .gsm_timer        (gsm_timer),
        .gsm_timer_running(gsm_timer_running),
        .done             (done),
        .flag             (flag),
        .trig             (trig),
        .busy             (busy),
        .err              (err),
        .hit_pend         (hit_pend),
        .miss_pend        (miss_pend)
    );

    initial begin
        clk_1mhz = 1'b0;
        forever #5 clk_1mhz = ~clk_1mhz;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    // Auto responder: raise done while trig is high, drop it once trig falls
    initial begin
        auto_val = 1'b0;
        forever begin
            @(negedge clk_1mhz);
            if (auto_en && trig && !auto_val) auto_val = 1'b1;
            else if (!trig) auto_val = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    initial begin
        logic prev;
        logic [3:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk_1mhz);
            if (trig && !prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_trig: flag=%b issued, required no command", flag);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_flag", 32'(flag), 32'(e));
                end
            end
            prev = trig;
        end
    end

    task automatic wait_pop(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_1mhz);
            n++;
        end
        check("pop_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk_1mhz);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic park();
        gsm_state = 3'd2; gsm_stage = 2'd0; gsm_lives = 2'd3;
        gsm_timer = 7'd50; gsm_timer_running = 1'b1;
    endtask

    task automatic pulse(input logic [2:0] ev);
        hit_pulse  = (ev == 3'd1);
        miss_pulse = (ev == 3'd2);
        btn_start  = (ev == 3'd3);
        btn_pause  = (ev == 3'd4);
        @(negedge clk_1mhz);
        hit_pulse = 1'b0; miss_pulse = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_1mhz);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_1mhz);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        vec[0]  = '{3'd0, 2'd0, 2'd3, 7'd50, 1'b1, 3'd3, 4'b1010, 1'b1};
        vec[1]  = '{3'd4, 2'd0, 2'd3, 7'd50, 1'b1, 3'd3, 4'b1000, 1'b1};
        vec[2]  = '{3'd3, 2'd0, 2'd3, 7'd50, 1'b1, 3'd3, 4'b1111, 1'b1};
        vec[3]  = '{3'd5, 2'd0, 2'd3, 7'd50, 1'b1, 3'd3, 4'b1111, 1'b1};
        vec[4]  = '{3'd1, 2'd0, 2'd3, 7'd50, 1'b1, 3'd4, 4'b0100, 1'b1};
        vec[5]  = '{3'd1, 2'd0, 2'd3, 7'd50, 1'b0, 3'd4, 4'b0101, 1'b1};
        vec[6]  = '{3'd1, 2'd1, 2'd2, 7'd30, 1'b1, 3'd1, 4'b0001, 1'b1};
        vec[7]  = '{3'd1, 2'd1, 2'd2, 7'd30, 1'b1, 3'd2, 4'b0010, 1'b1};
        vec[8]  = '{3'd1, 2'd1, 2'd0, 7'd30, 1'b1, 3'd0, 4'b1101, 1'b1};
        vec[9]  = '{3'd1, 2'd3, 2'd2, 7'd0,  1'b0, 3'd0, 4'b1110, 1'b1};
        vec[10] = '{3'd1, 2'd2, 2'd2, 7'd0,  1'b0, 3'd0, 4'b1100, 1'b1};
        vec[11] = '{3'd0, 2'd0, 2'd3, 7'd50, 1'b1, 3'd1, 4'b0000, 1'b0};
        vec[12] = '{3'd1, 2'd0, 2'd3, 7'd50, 1'b1, 3'd3, 4'b0000, 1'b0};
        vec[13] = '{3'd2, 2'd0, 2'd3, 7'd50, 1'b1, 3'd4, 4'b0000, 1'b0};

        rst_n = 1'b0;
        hit_pulse = 1'b0; miss_pulse = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
        manual = 1'b1; man_done = 1'b0; auto_en = 1'b0;
        park();
        gsm_state = 3'd0;

        // Reset values, then start with exact handshake timing
        repeat (3) @(negedge clk_1mhz);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hit_pend", 32'(hit_pend), 32'd0);
        check("rst_miss_pend", 32'(miss_pend), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(4'b1010);
        pulse(3'd3);
        check("start_c0_busy", 32'(busy), 32'd0);
        @(negedge clk_1mhz);
        check("start_c1_flag", 32'(flag), 32'hA);
        check("start_c1_trig", 32'(trig), 32'd0);
        check("start_c1_busy", 32'(busy), 32'd1);
        @(negedge clk_1mhz);
        check("start_c2_trig", 32'(trig), 32'd1);
        man_done = 1'b1;
        @(negedge clk_1mhz);
        check("start_c3_trig", 32'(trig), 32'd0);
        man_done = 1'b0;
        @(negedge clk_1mhz);
        check("start_gap1_busy", 32'(busy), 32'd1);
        @(negedge clk_1mhz);
        check("start_gap2_busy", 32'(busy), 32'd0);

        // Miss then three hits back to back
        manual = 1'b0; auto_en = 1'b1;
        park();
        gsm_state = 3'd1;
        exp_q.push_back(4'b0010);
        repeat (3) exp_q.push_back(4'b0001);
        pulse(3'd2);
        pulse(3'd1);
        pulse(3'd1);
        pulse(3'd1);
        wait_pop(60);
        wait_idle(30);
        check("order_hit_pend", 32'(hit_pend), 32'd0);
        check("order_miss_pend", 32'(miss_pend), 32'd0);
        park();

        for (int i = 0; i < 14; i++) begin
            @(negedge clk_1mhz);
            gsm_state = vec[i].st; gsm_stage = vec[i].stage; gsm_lives = vec[i].lives;
            gsm_timer = vec[i].timer; gsm_timer_running = vec[i].run;
            if (vec[i].issue) exp_q.push_back(vec[i].want);
            if (vec[i].ev != 3'd0) pulse(vec[i].ev);
            if (vec[i].issue) begin
                wait_pop(30);
                park();
                wait_idle(30);
            end else begin
                repeat (6) @(negedge clk_1mhz);
                check("vec_no_cmd_busy", 32'(busy), 32'd0);
                check("vec_no_cmd_hit_pend", 32'(hit_pend), 32'd0);
                park();
            end
        end

        // Saturation: 20 hits while the only command in flight never completes
        auto_en = 1'b0;
        @(negedge clk_1mhz);
        gsm_state = 3'd1;
        exp_q.push_back(4'b0001);
        hit_pulse = 1'b1;
        repeat (20) @(negedge clk_1mhz);
        hit_pulse = 1'b0;
        check("sat_hit_pend", 32'(hit_pend), 32'd15);
        check("sat_exp_empty", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        @(negedge clk_1mhz);
        rst_n = 1'b1;
        park();

        // Game over outranks queued hits; transition clears them
        manual = 1'b1; man_done = 1'b0;
        gsm_state = 3'd0;
        exp_q.push_back(4'b1010);
        pulse(3'd3);
        wait_pop(10);
        gsm_state = 3'd1;
        pulse(3'd1);
        pulse(3'd1);
        check("go_hit_pend_2", 32'(hit_pend), 32'd2);
        gsm_lives = 2'd0;
        exp_q.push_back(4'b1101);
        man_done = 1'b1;
        @(negedge clk_1mhz);
        man_done = 1'b0;
        wait_pop(20);
        check("go_hit_pend_cleared", 32'(hit_pend), 32'd0);
        park();
        manual = 1'b0; auto_en = 1'b1;
        wait_idle(30);

        // Timeout: trig held exactly 16 cycles, err sticky, sequencing continues
        auto_en = 1'b0;
        @(negedge clk_1mhz);
        gsm_state = 3'd0;
        exp_q.push_back(4'b1010);
        pulse(3'd3);
        n = 0;
        while (!trig && n < 10) begin
            @(negedge clk_1mhz);
            n++;
        end
        n = 0;
        while (trig && n < 40) begin
            n++;
            @(negedge clk_1mhz);
        end
        check("to_trig_cycles", 32'(n), 32'd16);
        check("to_err", 32'(err), 32'd1);
        wait_idle(30);
        auto_en = 1'b1;
        exp_q.push_back(4'b1010);
        pulse(3'd3);
        wait_pop(30);
        wait_idle(30);
        check("to_err_sticky", 32'(err), 32'd1);

        // Reset while trig is high
        auto_en = 1'b0;
        exp_q.push_back(4'b1010);
        pulse(3'd3);
        wait_pop(10);
        gsm_state = 3'd1;
        pulse(3'd1);
        pulse(3'd1);
        check("mid_trig_high", 32'(trig), 32'd1);
        rst_n = 1'b0;
        @(negedge clk_1mhz);
        check("mid_rst_trig", 32'(trig), 32'd0);
        check("mid_rst_hit_pend", 32'(hit_pend), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_flag", 32'(flag), 32'd0);
        park();
        rst_n = 1'b1;
        repeat (4) @(negedge clk_1mhz);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
